// File: rtl/add_sub_pkg.sv
// Shared mode encodings and FSM state type for the sequential add/sub block.
package add_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB
// so the caller can form signed overflow on the final slice.
module add_sub_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  // Ripple chain of full adders, LSB first.
  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    full_adder u_fa (
      .a    (a_s[i]),
      .b    (b_s[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit add/sub: one shared SLICE-bit adder, LSB slice first,
// operands in and result out over valid/ready handshakes.
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAST  = N - 1;

  // Reject geometries the slice datapath cannot cover exactly.
  if (WIDTH < 1 || (WIDTH % SLICE) != 0) begin : g_bad_geometry
    $error("add_sub_seq: WIDTH must be >= 1 and a multiple of SLICE");
  end

  state_e             state_q,     state_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic               carry_q,     carry_d;
  logic [WIDTH-1:0]   opa_q,       opa_d;
  logic [WIDTH-1:0]   opb_q,       opb_d;
  logic [WIDTH-1:0]   part_q,      part_d;
  logic [WIDTH-1:0]   sum_q,       sum_d;
  logic               cout_q,      cout_d;
  logic               ovf_q,       ovf_d;
  logic               zero_q,      zero_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [SLICE-1:0]   slice_a_c;
  logic [SLICE-1:0]   slice_b_c;
  logic [SLICE-1:0]   slice_s_c;
  logic               slice_cout_c;
  logic               slice_cmsb_c;
  logic [WIDTH-1:0]   part_upd_c;

  assign slice_a_c = opa_q[idx_q*SLICE +: SLICE];
  assign slice_b_c = opb_q[idx_q*SLICE +: SLICE];

  add_sub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_s   (slice_a_c),
    .b_s   (slice_b_c),
    .cin   (carry_q),
    .s     (slice_s_c),
    .cout  (slice_cout_c),
    .c_msb (slice_cmsb_c)
  );

  // Partial result with the current slice merged in at its bit position.
  always_comb begin
    part_upd_c = part_q;
    part_upd_c[idx_q*SLICE +: SLICE] = slice_s_c;
  end

  // Next-state and datapath update; subtract is a + ~b + 1 via carry-in.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    part_d   = part_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{mode}};
          carry_d = mode;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        part_d  = part_upd_c;
        carry_d = slice_cout_c;
        idx_d   = IDX_W'(idx_q + IDX_W'(1));
        if (idx_q == IDX_W'(LAST)) begin
          sum_d   = part_upd_c;
          cout_d  = slice_cout_c;
          ovf_d   = slice_cout_c ^ slice_cmsb_c;
          zero_d  = (part_upd_c == '0);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      part_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      part_q      <= part_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq: directed steps on the 16/4 configuration, then
// concurrent random sweeps on 16/1, 16/16 and 4/4, all scoreboard-checked.
module tb_add_sub_seq;

  logic clk;
  logic rst_n;
  logic go;

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- main 16/4 instance ----------------
  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        m_iv, m_ir, m_mode, m_ov, m_ordy, m_cout, m_ovf, m_zero;
  logic [15:0] m_a, m_b, m_sum;
  res_t        m_q[$];

  add_sub_seq #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_iv),
    .in_ready  (m_ir),
    .a         (m_a),
    .b         (m_b),
    .mode      (m_mode),
    .out_valid (m_ov),
    .out_ready (m_ordy),
    .sum       (m_sum),
    .cout      (m_cout),
    .ovf       (m_ovf),
    .zero      (m_zero)
  );

  function automatic res_t mk(input logic [15:0] s, input logic c, input logic v, input logic z);
    res_t r;
    r.sum = s; r.cout = c; r.ovf = v; r.zero = z;
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  32'(m_ir),   32'd1);
    check({tag, " out_valid"}, 32'(m_ov),   32'd0);
    check({tag, " sum"},       32'(m_sum),  32'd0);
    check({tag, " cout"},      32'(m_cout), 32'd0);
    check({tag, " ovf"},       32'(m_ovf),  32'd0);
    check({tag, " zero"},      32'(m_zero), 32'd0);
  endtask

  // Present operands, confirm acceptance, then scramble inputs after the accept edge.
  task automatic m_issue(input logic [15:0] xa, input logic [15:0] xb, input logic md, input res_t exp);
    @(posedge clk); #1;
    m_a = xa; m_b = xb; m_mode = md; m_iv = 1'b1;
    @(negedge clk);
    check("in_ready before accept", 32'(m_ir), 32'd1);
    m_q.push_back(exp);
    @(posedge clk); #1;
    m_iv = 1'b0; m_a = ~xa; m_b = 16'($urandom); m_mode = ~md;
  endtask

  // Wait (bounded) for out_valid, check latency and pop/compare the result.
  task automatic m_collect(input string tag, input int lat);
    int   cnt;
    res_t e;
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk); cnt++; #1;
      if (m_ov) break;
    end
    check({tag, " latency"}, 32'(cnt), 32'(lat));
    check({tag, " out_valid"}, 32'(m_ov), 32'd1);
    if (m_ov) begin
      if (m_q.size() == 0) begin
        check({tag, " scoreboard depth"}, 32'(m_q.size()), 32'd1);
      end else begin
        e = m_q.pop_front();
        check({tag, " sum"},  32'(m_sum),  32'(e.sum));
        check({tag, " cout"}, 32'(m_cout), 32'(e.cout));
        check({tag, " ovf"},  32'(m_ovf),  32'(e.ovf));
        check({tag, " zero"}, 32'(m_zero), 32'(e.zero));
      end
    end
  endtask

  // ---------------- random sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned SW = (g == 2) ? 4 : 16;
    localparam int unsigned SS = (g == 0) ? 1 : ((g == 1) ? 16 : 4);

    typedef struct packed {
      logic [SW-1:0] sum;
      logic          cout;
      logic          ovf;
      logic          zero;
    } sres_t;

    logic          iv, ir, md, ov, ordy, co, vf, zr;
    logic [SW-1:0] sa, sb, sm;
    logic          done;
    sres_t         sq[$];
    sres_t         e;

    add_sub_seq #(.WIDTH(SW), .SLICE(SS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (sa),
      .b         (sb),
      .mode      (md),
      .out_valid (ov),
      .out_ready (ordy),
      .sum       (sm),
      .cout      (co),
      .ovf       (vf),
      .zero      (zr)
    );

    function automatic sres_t model(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic sub);
      logic [SW-1:0] yy;
      logic [SW:0]   full;
      sres_t         r;
      yy     = sub ? ~y : y;
      full   = {1'b0, x} + {1'b0, yy} + (SW+1)'(sub);
      r.sum  = full[SW-1:0];
      r.cout = full[SW];
      r.ovf  = (x[SW-1] == yy[SW-1]) && (r.sum[SW-1] != x[SW-1]);
      r.zero = (r.sum == '0);
      return r;
    endfunction

    // Scoreboard pop on every completed output handshake.
    always @(negedge clk) begin
      if (go && rst_n && ov && ordy) begin
        if (sq.size() == 0) begin
          check($sformatf("sweep%0d spurious result", g), 32'(sq.size()), 32'd1);
        end else begin
          e = sq.pop_front();
          check($sformatf("sweep%0d result", g), 32'({sm, co, vf, zr}), 32'(e));
        end
      end
    end

    initial begin
      int k;
      iv = 1'b0; ordy = 1'b0; sa = '0; sb = '0; md = 1'b0; done = 1'b0;
      wait (go);
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk); #1;
        sa = SW'($urandom); sb = SW'($urandom); md = 1'($urandom); iv = 1'b1;
        k = 0;
        @(negedge clk);
        while (!ir && k < 20) begin
          @(negedge clk); k++;
        end
        check($sformatf("sweep%0d accept", g), 32'(ir), 32'd1);
        if (ir) sq.push_back(model(sa, sb, md));
        @(posedge clk); #1;
        k = 0;
        while (k < 200) begin
          if (sq.size() == 0) break;
          iv   = 1'($urandom);
          sa   = SW'($urandom);
          sb   = SW'($urandom);
          md   = 1'($urandom);
          ordy = 1'($urandom);
          @(posedge clk); #1; k++;
        end
        iv = 1'b0; ordy = 1'b0;
        check($sformatf("sweep%0d drain", g), 32'(sq.size()), 32'd0);
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    res_t bp;
    n_vec = 0; n_err = 0; go = 1'b0;
    m_iv = 1'b0; m_ordy = 1'b1; m_a = '0; m_b = '0; m_mode = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    m_issue(16'h1234, 16'h0FF0, 1'b0, mk(16'h2224, 1'b0, 1'b0, 1'b0)); m_collect("add 1234+0ff0", 4);
    m_issue(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0)); m_collect("sub 5-7", 4);
    m_issue(16'h0007, 16'h0005, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0)); m_collect("sub 7-5", 4);
    m_issue(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0)); m_collect("add 7fff+1", 4);
    m_issue(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0)); m_collect("sub 8000-1", 4);
    m_issue(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1)); m_collect("add ffff+1", 4);
    m_issue(16'hA5A5, 16'hA5A5, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1)); m_collect("sub a5a5-a5a5", 4);

    // Backpressure: hold the result, offer an ignored second operation.
    @(posedge clk); #1;
    m_ordy = 1'b0;
    bp = mk(16'h5555, 1'b0, 1'b0, 1'b0);
    m_issue(16'h1234, 16'h4321, 1'b0, bp); m_collect("bp add", 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      m_iv = 1'b1; m_a = 16'hFFFF; m_b = 16'h0001; m_mode = 1'b0;
      check("bp hold sum",       32'(m_sum),  32'(bp.sum));
      check("bp hold cout",      32'(m_cout), 32'(bp.cout));
      check("bp hold ovf",       32'(m_ovf),  32'(bp.ovf));
      check("bp hold zero",      32'(m_zero), 32'(bp.zero));
      check("bp hold in_ready",  32'(m_ir),   32'd0);
      check("bp hold out_valid", 32'(m_ov),   32'd1);
    end
    m_ordy = 1'b1; m_iv = 1'b0;
    @(posedge clk); #1;
    check("bp release in_ready",  32'(m_ir), 32'd1);
    check("bp release out_valid", 32'(m_ov), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle no result", 32'(m_ov),  32'd0);
      check("idle sum held",  32'(m_sum), 32'(bp.sum));
    end

    // Reset two CALC cycles into an operation.
    m_issue(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid-calc reset");
    m_q.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("aborted op silent", 32'(m_ov), 32'd0);
    end
    m_issue(16'h0100, 16'h0001, 1'b1, mk(16'h00FF, 1'b1, 1'b0, 1'b0)); m_collect("post-reset sub", 4);

    // Random sweeps on the other geometries.
    @(posedge clk); #1;
    go = 1'b1;
    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 80000) begin
      @(posedge clk); t++;
    end
    check("sweeps complete", 32'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised, multi-cycle two's-complement adder/subtractor that generalises the team's 4-bit ripple add/sub to any WIDTH. It processes SLICE bits per clock through one shared slice adder and accepts operands over a valid/ready handshake. It returns the result with carry, signed-overflow and zero flags over a second valid/ready handshake. It sits in the datapath wherever a wide add/sub is needed and area matters more than latency.

## Interface
- WIDTH, 16, operand/result width in bits; WIDTH ≥ 1.
- SLICE, 4, bits processed per cycle; WIDTH % SLICE == 0 (elaboration error otherwise).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend / addend.
- b  in  WIDTH  subtrahend / addend.
- mode  in  1  0 = add (a+b), 1 = subtract (a−b).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow, carry-into-MSB XOR carry-out.
- zero  out  1  sum == 0.

## Operation
- Three states: IDLE, CALC, DONE. N = WIDTH/SLICE.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - Latch a and b XOR {WIDTH{mode}}.
  - Set carry = mode and slice index = 0.
  - Go to CALC.
- CALC: each cycle the slice adder combines a/b slice[index] with carry.
  - Slice result goes into the partial register; carry is updated; index increments.
  - On index == N−1: load sum, cout, ovf (using the slice's MSB carry-in) and zero into the output registers, then go to DONE.
- DONE: out_valid = 1. On out_ready, go to IDLE.
- in_ready is 0 in CALC and DONE. in_valid is ignored there; operands are not queued.
- a, b and mode are sampled only on the accept edge. Later changes have no effect on the operation in flight.
- sum and flags change only on entry to DONE. They hold their value through IDLE until the next result.
- Wrap-around: the sum is truncated to WIDTH; the carry leaves only via cout.
- N == 1 (SLICE == WIDTH): CALC lasts one cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - State goes to IDLE, index and carry to 0.
  - Outputs: in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0.
- Reset mid-operation (CALC or DONE) aborts the operation and discards the result; no out_valid is produced.
- Latency: out_valid rises N cycles after the accept edge. With WIDTH = 16, SLICE = 4, the accept at edge k gives out_valid high after edge k+4.
- Throughput: one operation per N+2 cycles at best (accept, N CALC, DONE→IDLE).
- While out_valid && !out_ready, sum and all flags are held stable.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.

## Structure
- Package add_sub_pkg holds:
  - MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
  - The state enum {IDLE, CALC, DONE}.
- Sub-module add_sub_slice (parameter SLICE) is a combinational ripple of the existing full_adder cells.
  - Inputs: a_s, b_s, cin.
  - Outputs: s, cout, c_msb (carry into the slice MSB, used for ovf).
- The top holds the FSM, index counter, operand/partial registers and output registers.

## Test plan
- WIDTH=16, SLICE=4, add 0x1234 + 0x0FF0 → sum 0x2224, cout 0, ovf 0, zero 0; out_valid exactly 4 cycles after accept.
- Subtract 0x0005 − 0x0007 → 0xFFFE, cout 0, ovf 0. Subtract 0x0007 − 0x0005 → 0x0002, cout 1.
- Overflow:
  - Add 0x7FFF + 0x0001 → 0x8000, ovf 1, cout 0.
  - Subtract 0x8000 − 0x0001 → 0x7FFF, ovf 1, cout 1.
- Zero/wrap:
  - Add 0xFFFF + 0x0001 → 0x0000, cout 1, zero 1, ovf 0.
  - Subtract 0xA5A5 − 0xA5A5 → 0x0000, cout 1, zero 1.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles in DONE; sum and flags stay stable, in_ready stays 0.
  - A second in_valid with new operands is ignored.
  - Release out_ready; in_ready = 1 on the next cycle.
- Reset and parameter sweep:
  - Assert rst_n = 0 after 2 CALC cycles; all outputs go to reset values immediately and no result appears. The next operation is correct.
  - Repeat 1000 random operations, including changing a, b and mode mid-CALC, at (WIDTH, SLICE) = (16,1), (16,16) and (4,4). Check every result against a ± b mod 2^WIDTH.
